// File: rtl/rr_packet_arbiter.sv
// rtl/rr_packet_arbiter.sv - round-robin output-port arbiter holding grant for a whole wormhole packet
module rr_packet_arbiter #(
  parameter int                NPORTS      = 5,
  parameter int                LEN_W       = 12,
  parameter int                TYPE_W      = 3,
  parameter logic [TYPE_W-1:0] HEADER_CODE = 3'b001,
  parameter logic [TYPE_W-1:0] TAIL_CODE   = 3'b100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        req,
  input  logic [NPORTS*TYPE_W-1:0] flit_type,
  input  logic [NPORTS*LEN_W-1:0]  length,
  input  logic                     fire,
  output logic [NPORTS-1:0]        grant,
  output logic                     idle,
  output logic [LEN_W-1:0]         remaining,
  output logic                     len_err
);
  localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d, win_q, win_d;
  logic [NPORTS-1:0]  grant_d, mask;
  logic [LEN_W-1:0]   rem_d, load_len;
  logic               len_err_d, do_release, load;
  logic [IDX_W-1:0]   base, load_idx;
  logic [IDX_W:0]     pick;
  logic [TYPE_W-1:0]  cur_type;

  // Headers are recognised upstream; the length field is simply sampled at grant time.
  logic unused_hdr;
  assign unused_hdr = ^HEADER_CODE;

  // Returns {found, index} of the first set bit of r searching base+1, base+2, ... modulo NPORTS.
  function automatic logic [IDX_W:0] rr_pick(input logic [NPORTS-1:0] r, input logic [IDX_W-1:0] b);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = NPORTS; k >= 1; k--) begin
      idx = (int'(b) + k) % NPORTS;
      if (r[idx]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    win_d      = win_q;
    grant_d    = grant;
    rem_d      = remaining;
    len_err_d  = 1'b0;
    do_release = 1'b0;
    load       = 1'b0;
    base       = last_q;
    mask       = req;
    // While locked, a release re-arbitrates with the current winner excluded and at lowest priority.
    if (state_q == S_LOCKED) begin
      base = win_q;
      mask = req & ~(NPORTS'(1) << win_q);
    end
    pick     = rr_pick(mask, base);
    load_idx = pick[IDX_W-1:0];
    cur_type = flit_type[int'(win_q)*TYPE_W +: TYPE_W];

    unique case (state_q)
      S_IDLE: load = pick[IDX_W];
      S_LOCKED: begin
        if (fire) begin
          if (cur_type == TAIL_CODE || remaining == LEN_W'(1)) begin
            do_release = 1'b1;
            len_err_d  = (remaining == LEN_W'(1)) && (cur_type != TAIL_CODE);
          end else begin
            rem_d = remaining - LEN_W'(1);
          end
        end else if (!req[win_q]) begin
          do_release = 1'b1;
        end
        if (do_release) begin
          last_d = win_q;
          if (pick[IDX_W]) begin
            load = 1'b1;
          end else if (req[win_q]) begin
            load     = 1'b1;
            load_idx = win_q;
          end else begin
            state_d = S_IDLE;
            grant_d = '0;
            rem_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    load_len = length[int'(load_idx)*LEN_W +: LEN_W];
    if (load) begin
      state_d = S_LOCKED;
      win_d   = load_idx;
      grant_d = NPORTS'(1) << load_idx;
      rem_d   = (load_len == '0) ? LEN_W'(1) : load_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= IDX_W'(NPORTS - 1);
      win_q     <= '0;
      grant     <= '0;
      idle      <= 1'b1;
      remaining <= '0;
      len_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      grant     <= grant_d;
      idle      <= (state_d == S_IDLE);
      remaining <= rem_d;
      len_err   <= len_err_d;
    end
  end
endmodule

// File: tb/tb_rr_packet_arbiter.sv
// tb/tb_rr_packet_arbiter.sv - vector table + scoreboard bench for rr_packet_arbiter
module tb_rr_packet_arbiter;
  localparam logic [2:0] H = 3'b001, B = 3'b010, T = 3'b100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  req = '0;
  logic [14:0] flit_type = '0;
  logic [59:0] length = '0;
  logic        fire = 1'b0;
  logic [4:0]  grant;
  logic        idle;
  logic [11:0] remaining;
  logic        len_err;

  int checks = 0;
  int errors = 0;

  rr_packet_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .flit_type(flit_type), .length(length),
    .fire(fire), .grant(grant), .idle(idle), .remaining(remaining), .len_err(len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [4:0]  req;
    logic [2:0]  typ;
    logic [11:0] len;
    logic        fire;
    logic [4:0]  g;
    logic        idl;
    logic [11:0] rem;
    logic        err;
  } vec_t;

  typedef struct {
    string       name;
    logic [18:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  function automatic vec_t mk(input logic r, input logic [4:0] rq, input logic [2:0] ty,
                              input logic [11:0] ln, input logic f, input logic [4:0] g,
                              input logic idl, input logic [11:0] rem, input logic err);
    vec_t v;
    v.rst = r; v.req = rq; v.typ = ty; v.len = ln; v.fire = f;
    v.g = g; v.idl = idl; v.rem = rem; v.err = err;
    return v;
  endfunction

  task automatic check_out(input string name);
    sb_t         e;
    logic [18:0] act;
    act = {grant, idle, remaining, len_err};
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got grant=%b idle=%b rem=%0d err=%b want grant=%b idle=%b rem=%0d err=%b",
                 name, act[18:14], act[13], act[12:1], act[0],
                 e.exp[18:14], e.exp[13], e.exp[12:1], e.exp[0]);
      end
    end
  endtask

  task automatic drive(input vec_t v);
    rst       = v.rst;
    req       = v.req;
    flit_type = {5{v.typ}};
    length    = {5{v.len}};
    fire      = v.fire;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, two-channel back-to-back handoff, single-requester regrant, abort to idle
    vecs.push_back(mk(1, 5'b00000, H, 12'd0, 0, 5'b00000, 1, 12'd0, 0));
    vecs.push_back(mk(0, 5'b00110, H, 12'd3, 0, 5'b00010, 0, 12'd3, 0));
    vecs.push_back(mk(0, 5'b00110, B, 12'd3, 1, 5'b00010, 0, 12'd2, 0));
    vecs.push_back(mk(0, 5'b00110, B, 12'd3, 1, 5'b00010, 0, 12'd1, 0));
    vecs.push_back(mk(0, 5'b00110, T, 12'd3, 1, 5'b00100, 0, 12'd3, 0));
    vecs.push_back(mk(0, 5'b00100, B, 12'd3, 1, 5'b00100, 0, 12'd2, 0));
    vecs.push_back(mk(0, 5'b00100, B, 12'd3, 1, 5'b00100, 0, 12'd1, 0));
    vecs.push_back(mk(0, 5'b00100, T, 12'd3, 1, 5'b00100, 0, 12'd3, 0));
    vecs.push_back(mk(0, 5'b00000, B, 12'd3, 0, 5'b00000, 1, 12'd0, 0));
    // All five requesting, length-2 packets, full rotation with wrap
    vecs.push_back(mk(1, 5'b11111, H, 12'd2, 0, 5'b00000, 1, 12'd0, 0));
    vecs.push_back(mk(0, 5'b11111, H, 12'd2, 0, 5'b00001, 0, 12'd2, 0));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(0, 5'b11111, B, 12'd2, 1, 5'(1 << i), 0, 12'd1, 0));
      vecs.push_back(mk(0, 5'b11111, T, 12'd2, 1, 5'(1 << ((i + 1) % 5)), 0, 12'd2, 0));
    end
    // Channel 3, length 4, fire stalled three cycles
    vecs.push_back(mk(1, 5'b00000, H, 12'd4, 0, 5'b00000, 1, 12'd0, 0));
    vecs.push_back(mk(0, 5'b01000, H, 12'd4, 0, 5'b01000, 0, 12'd4, 0));
    vecs.push_back(mk(0, 5'b01000, B, 12'd4, 1, 5'b01000, 0, 12'd3, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 5'b01000, B, 12'd4, 0, 5'b01000, 0, 12'd3, 0));
    vecs.push_back(mk(0, 5'b01000, B, 12'd4, 1, 5'b01000, 0, 12'd2, 0));
    vecs.push_back(mk(0, 5'b01000, B, 12'd4, 1, 5'b01000, 0, 12'd1, 0));
    vecs.push_back(mk(0, 5'b00000, T, 12'd4, 1, 5'b00000, 1, 12'd0, 0));
    vecs.push_back(mk(0, 5'b00000, T, 12'd4, 1, 5'b00000, 1, 12'd0, 0));
    // Count exhausted on a BODY flit: len_err pulse, handoff to channel 1
    vecs.push_back(mk(1, 5'b00000, H, 12'd2, 0, 5'b00000, 1, 12'd0, 0));
    vecs.push_back(mk(0, 5'b00011, H, 12'd2, 0, 5'b00001, 0, 12'd2, 0));
    vecs.push_back(mk(0, 5'b00011, B, 12'd2, 1, 5'b00001, 0, 12'd1, 0));
    vecs.push_back(mk(0, 5'b00011, B, 12'd2, 1, 5'b00010, 0, 12'd2, 1));
    vecs.push_back(mk(0, 5'b00011, B, 12'd2, 0, 5'b00010, 0, 12'd2, 0));
    // Zero length treated as one; channel 4 aborts, search resumes at channel 0
    vecs.push_back(mk(1, 5'b00000, H, 12'd0, 0, 5'b00000, 1, 12'd0, 0));
    vecs.push_back(mk(0, 5'b10100, H, 12'd0, 0, 5'b00100, 0, 12'd1, 0));
    vecs.push_back(mk(0, 5'b10100, T, 12'd6, 1, 5'b10000, 0, 12'd6, 0));
    vecs.push_back(mk(0, 5'b10100, B, 12'd6, 1, 5'b10000, 0, 12'd5, 0));
    vecs.push_back(mk(0, 5'b00101, B, 12'd7, 0, 5'b00001, 0, 12'd7, 0));
    // Reset mid-packet with remaining=7, then lowest-index requester wins
    vecs.push_back(mk(1, 5'b00101, B, 12'd7, 1, 5'b00000, 1, 12'd0, 0));
    vecs.push_back(mk(0, 5'b00110, H, 12'd3, 0, 5'b00010, 0, 12'd3, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      sb.push_back('{$sformatf("vec%0d", i), {vecs[i].g, vecs[i].idl, vecs[i].rem, vecs[i].err}});
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i));
    end

    // Inputs changing between edges must not reach the outputs
    req  = 5'b00000;
    fire = 1'b1;
    flit_type = {5{T}};
    sb.push_back('{"no_comb_path", {5'b00010, 1'b0, 12'd3, 1'b0}});
    #2;
    check_out("no_comb_path");
    fire = 1'b0;
    sb.push_back('{"abort_to_idle", {5'b00000, 1'b1, 12'd0, 1'b0}});
    @(posedge clk);
    #1;
    check_out("abort_to_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_packet_arbiter.md
# rr_packet_arbiter

Parametrised round-robin output-port arbiter for the mesh router; one instance per output port. It grants one of NPORTS input channels and holds the grant for a whole wormhole packet. Release happens on the TAIL flit or when the header-declared flit count is exhausted, whichever comes first. On release it re-arbitrates in the same cycle, with the last-served channel at lowest priority.

## Interface
- NPORTS, 5, number of requesting input channels (≥2); index 0 = Local, then N, E, S, W
- LEN_W, 12, width of packet length field (flits)
- TYPE_W, 3, width of flit-type field
- HEADER_CODE, 3'b001, flit_type value of a header flit
- TAIL_CODE, 3'b100, flit_type value of a tail flit

- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- req  in  NPORTS  per-channel request (channel holds a flit for this output)
- flit_type  in  NPORTS*TYPE_W  per-channel type of head-of-queue flit; channel i at [i*TYPE_W +: TYPE_W]
- length  in  NPORTS*LEN_W  per-channel packet length, valid with header; channel i at [i*LEN_W +: LEN_W]
- fire  in  1  a flit of the granted channel crosses the crossbar this cycle
- grant  out  NPORTS  registered one-hot grant; all-zero when idle
- idle  out  1  registered; 1 when no channel is granted
- remaining  out  LEN_W  registered count of flits still owed by the current packet
- len_err  out  1  one-cycle pulse: count exhausted while the last flit's type ≠ TAIL_CODE

## Operation
- States: IDLE (grant=0, idle=1), LOCKED (grant one-hot, idle=0).
- Pointer `last` (index, reset NPORTS-1) marks the last-served channel. Search order is last+1, last+2, … wrapping modulo NPORTS; the first asserted req wins.
- IDLE: if any req, enter LOCKED with grant=winner and remaining=winner's length. If length==0, load 1. No req: stay IDLE.
- LOCKED, per cycle:
  - fire=1 and (winner type==TAIL_CODE or remaining==1) → release.
  - fire=1 otherwise → remaining−1.
  - req[winner]=0 with fire=0 → release (abort). No flit counted.
  - fire=0 and req[winner]=1 → hold, no change.
- Release:
  - last ← winner.
  - len_err=1 if remaining==1 and type≠TAIL_CODE. A TAIL arriving with remaining>1 releases silently.
  - Re-arbitrate in the same cycle over req excluding the winner. If that finds a winner, go straight to LOCKED with the new grant and length (back-to-back, no idle cycle).
  - If the releasing winner is the only requester, it is re-granted and reloads its length.
  - No requester → IDLE.
- fire while IDLE is ignored.
- remaining does not wrap below 1 while LOCKED. It is 0 in IDLE.

## Timing
- Reset values: grant=0, idle=1, remaining=0, len_err=0, last=NPORTS-1, state IDLE.
- rst takes precedence over all inputs. Reset mid-packet drops the grant at the next edge; no len_err pulse.
- Latency req→grant: 1 cycle from IDLE.
- Release→next grant: the new grant is visible at the edge that retires the tail. Zero bubble cycles.
- fire is sampled in the cycle grant is high. The tail's fire cycle is the last cycle of the old grant.
- len_err is registered and asserted for exactly the cycle after the release edge.
- Any single input change affects outputs only at the next edge. No combinational input→output path.

## Test plan
- Reset, then req=5'b00110 → grant=5'b00010 after 1 cycle. That packet completes (length 3, 3 fires, 3rd TAIL) → next cycle grant=5'b00100, no idle cycle.
- All 5 req held continuously, each packet length 2 with a TAIL → grants cycle 0→1→2→3→4→0, each held exactly 2 fire cycles.
- Single channel 3, length 4, fire stalled (fire=0) 3 cycles mid-packet → grant held, remaining frozen at its value; released only after the 4th fire.
- Channel 0 length 2, second flit type BODY, channel 1 waiting → release after 2nd fire, len_err pulses 1 cycle, grant=5'b00010.
- Channel 2 length 0 → treated as 1; released on first fire. Channel 4 drops req mid-packet with fire=0 → release, last=4, next search starts at 0.
- rst asserted while LOCKED with remaining=7 → next edge grant=0, idle=1, remaining=0, len_err=0; after rst, first grant goes to lowest-index requester.
